// File: rtl/fetch.sv
// Instruction fetch: credit-limited request stream, in-order response FIFO, redirect with drain.
// Optional same-cycle response bypass to decode is enabled by defining FETCH_BYPASS_EN.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid_de0,
  output logic [31:0] instr_de0,
  output logic [31:0] pc_de0,
  input  logic        stall_de0
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [63:0]   buf_q [BUF_DEPTH];

  logic [CW:0]   credit_used;
  logic [CW-1:0] redir_discard;
  logic [31:0]   redirect_pc_al;
  logic          fifo_empty;
  logic          req_accept;
  logic          rsp_ret;
  logic          rsp_kept;
  logic          push;
  logic          pop;
  logic          unused_bits;

  assign unused_bits    = ^redirect_pc[1:0];
  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};
  assign fifo_empty     = (count_q == '0);
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};

  assign imem_req_valid = (state_q == S_FETCH) && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;

  // A response only retires outstanding work if something is actually in flight.
  assign rsp_ret        = imem_rsp_valid && (outst_q != '0);
  assign rsp_kept       = (state_q == S_FETCH) && imem_rsp_valid && !redirect_valid;
  assign redir_discard  = rsp_ret ? (outst_q - 1'b1) : outst_q;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit      = rsp_kept && fifo_empty;
  assign instr_valid_de0 = (!fifo_empty || bypass_hit) && !redirect_valid;
  assign instr_de0       = bypass_hit ? imem_rsp_data : buf_q[rd_ptr_q][31:0];
  assign pc_de0          = bypass_hit ? rsp_pc_q : buf_q[rd_ptr_q][63:32];
  assign pop             = instr_valid_de0 && !stall_de0 && !fifo_empty;
  // A bypassed word consumed by decode never enters the buffer.
  assign push            = rsp_kept && !(bypass_hit && !stall_de0);
`else
  assign instr_valid_de0 = !fifo_empty && !redirect_valid;
  assign instr_de0       = buf_q[rd_ptr_q][31:0];
  assign pc_de0          = buf_q[rd_ptr_q][63:32];
  assign pop             = instr_valid_de0 && !stall_de0;
  assign push            = rsp_kept;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    case ({req_accept, rsp_ret})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (req_accept) pc_d = pc_q + 32'd4;
    if (rsp_kept)   rsp_pc_d = rsp_pc_q + 32'd4;
    if (push)       wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)        rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_DRAIN: begin
        if (imem_rsp_valid && (discard_q != '0)) begin
          discard_d = discard_q - 1'b1;
          if (discard_q == CW'(1)) state_d = S_FETCH;
        end
      end
      default: state_d = state_q;
    endcase

    // Redirect overrides everything; a later redirect simply restarts the drain count.
    if (redirect_valid) begin
      pc_d      = redirect_pc_al;
      rsp_pc_d  = redirect_pc_al;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      discard_d = redir_discard;
      state_d   = (redir_discard != '0) ? S_DRAIN : S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      rsp_pc_q  <= {RESET_PC[31:2], 2'b00};
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Buffer storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= {rsp_pc_q, imem_rsp_data};
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order memory model with programmable latency and hold-off, plus a
// stream-level reference (expected request PC and expected decode PC) reset on each redirect.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid_de0;
  logic [31:0] instr_de0;
  logic [31:0] pc_de0;
  logic        stall_de0;

  fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid_de0 (instr_valid_de0),
    .instr_de0       (instr_de0),
    .pc_de0          (pc_de0),
    .stall_de0       (stall_de0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          gate;
  int          lat_min, lat_max;
  int          cyc = 0;

  // stream reference
  logic [31:0] exp_req_pc, exp_dec_pc;
  int          acc_cnt, dlv_cnt, rst_cnt;
  int          first_acc_cyc, first_vld_cyc;
  logic [31:0] first_vld_pc;
  logic        quiet_chk;
  logic        last_req_valid, last_instr_valid;
  logic [31:0] last_req_addr;
  logic [31:0] rd_acc[3];
  int          rd_nacc;
  logic [31:0] rd_first_dlv;
  logic        rd_got_dlv;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic cycle();
    int lat;
    if (mq_due.size() > 0 && mq_due[0] <= cyc && gate != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      if (gate > 0) gate--;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    last_req_valid   = imem_req_valid;
    last_req_addr    = imem_req_addr;
    last_instr_valid = instr_valid_de0;
    if (reset) begin
      rst_cnt++;
      if (rst_cnt >= 2) begin
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid_de0}, 32'd0);
      end
    end else begin
      if (quiet_chk) begin
        chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("post_rst_instr_valid", {31'd0, instr_valid_de0}, 32'd0);
        quiet_chk = 1'b0;
      end
      if (redirect_valid) begin
        chk("req_in_redirect", {31'd0, imem_req_valid}, 32'd0);
        chk("dec_in_redirect", {31'd0, instr_valid_de0}, 32'd0);
      end
      if (instr_valid_de0 && first_vld_cyc < 0) begin
        first_vld_cyc = cyc;
        first_vld_pc  = pc_de0;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req_pc);
        exp_req_pc += 32'd4;
        lat = lat_min + int'($urandom_range(0, lat_max - lat_min));
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        if (rd_nacc < 3) rd_acc[rd_nacc] = imem_req_addr;
        rd_nacc++;
        acc_cnt++;
      end
      if (instr_valid_de0 && !stall_de0) begin
        chk("dec_pc", pc_de0, exp_dec_pc);
        chk("dec_instr", instr_de0, memfn(exp_dec_pc));
        if (!rd_got_dlv) begin
          rd_first_dlv = pc_de0;
          rd_got_dlv   = 1'b1;
        end
        exp_dec_pc += 32'd4;
        dlv_cnt++;
      end
      if (redirect_valid) begin
        exp_req_pc   = {redirect_pc[31:2], 2'b00};
        exp_dec_pc   = {redirect_pc[31:2], 2'b00};
        rd_nacc      = 0;
        rd_acc[0]    = 32'hDEAD_BEEF;
        rd_acc[1]    = 32'hDEAD_BEEF;
        rd_acc[2]    = 32'hDEAD_BEEF;
        rd_first_dlv = 32'hDEAD_BEEF;
        rd_got_dlv   = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    rst_cnt = 0;
    for (int i = 0; i < 3; i++) cycle();
    reset         = 1'b0;
    quiet_chk     = 1'b1;
    first_acc_cyc = -1;
    first_vld_cyc = -1;
    first_vld_pc  = 32'hDEAD_BEEF;
    acc_cnt       = 0;
    dlv_cnt       = 0;
    rd_nacc       = 0;
    rd_got_dlv    = 1'b0;
    exp_req_pc    = RST_PC;
    exp_dec_pc    = RST_PC;
  endtask

  initial begin
    int n0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    stall_de0 = 1'b0; gate = -1; lat_min = 1; lat_max = 1; quiet_chk = 1'b0;

    // reset release, 1-cycle memory, back-to-back stream
    do_reset();
    for (int i = 0; i < 12; i++) cycle();
    chk("t1_accepts", 32'(acc_cnt), 32'd11);
    chk("t1_first_latency", 32'(first_vld_cyc - first_acc_cyc), 32'(FIRST_LAT));
    chk("t1_first_pc", first_vld_pc, RST_PC);

    // decode stalled: credits cap issue at DEPTH
    stall_de0 = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) cycle();
    chk("t2_accepts", 32'(acc_cnt), 32'(DEPTH));
    chk("t2_req_blocked", {31'd0, last_req_valid}, 32'd0);
    stall_de0 = 1'b0;
    n0 = acc_cnt;
    for (int i = 0; i < 12; i++) cycle();
    chk("t2_resumed", {31'd0, acc_cnt > n0}, 32'd1);
    chk("t2_delivered", {31'd0, dlv_cnt > DEPTH}, 32'd1);

    // three outstanding, redirect with a response in the same cycle
    gate = 0;
    do_reset();
    for (int i = 0; i < 10 && acc_cnt < 3; i++) cycle();
    imem_req_ready = 1'b0;
    chk("t3_outstanding", 32'(acc_cnt), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; gate = 1;
    cycle();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; gate = 0;
    cycle();
    chk("t3_drain_no_req", {31'd0, last_req_valid}, 32'd0);
    gate = -1;
    for (int i = 0; i < 12; i++) cycle();
    chk("t3_first_req", rd_acc[0], 32'h0000_2000);
    chk("t3_first_dec", rd_first_dlv, 32'h0000_2000);

    // redirect with nothing outstanding and a full buffer
    stall_de0 = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) cycle();
    chk("t4_req_blocked", {31'd0, last_req_valid}, 32'd0);
    chk("t4_buf_nonempty", {31'd0, last_instr_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("t4_req_valid", {31'd0, last_req_valid}, 32'd1);
    chk("t4_req_addr", last_req_addr, 32'h0000_4000);
    chk("t4_flushed", {31'd0, last_instr_valid}, 32'd0);
    stall_de0 = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("t4_first_dec", rd_first_dlv, 32'h0000_4000);

    // address wrap (low bits of redirect_pc are ignored)
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    chk("t5_wrap0", rd_acc[0], 32'hFFFF_FFF8);
    chk("t5_wrap1", rd_acc[1], 32'hFFFF_FFFC);
    chk("t5_wrap2", rd_acc[2], 32'h0000_0000);

    // second redirect during drain wins
    gate = 0;
    for (int i = 0; i < 4; i++) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    cycle();
    redirect_pc = 32'h0000_3000;
    cycle();
    redirect_valid = 1'b0; gate = -1;
    for (int i = 0; i < 15; i++) cycle();
    chk("t6_first_req", rd_acc[0], 32'h0000_3000);
    chk("t6_first_dec", rd_first_dlv, 32'h0000_3000);

    // randomized traffic against the stream reference
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall_de0      = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ?
                       (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      cycle();
    end
    redirect_valid = 1'b0; stall_de0 = 1'b0; imem_req_ready = 1'b1;
    n0 = dlv_cnt;
    for (int i = 0; i < 20; i++) cycle();
    chk("final_progress", {31'd0, dlv_cnt > n0}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  redirect request from a later stage.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored.
- imem_req_valid  output  1  instruction memory request.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- instr_valid_de0  output  1  instruction presented to decode.
- instr_de0  output  32  instruction to decode (t_rv_instr layout).
- pc_de0  output  32  PC of instr_de0.
- stall_de0  input  1  decode cannot accept this cycle.

Function
REQ-004 SHALL implement states IDLE, FETCH and DRAIN; reset enters IDLE; IDLE -> FETCH unconditionally the next cycle.
REQ-005 SHALL hold fetch PC pc_q and response PC rsp_pc_q; pc_q += 4 per accepted request, rsp_pc_q += 4 per kept response; 32-bit wrap, 32'hFFFF_FFFC -> 0.
REQ-006 SHALL drive imem_req_valid=1 only in FETCH, with redirect_valid=0 and (buffer occupancy + outstanding) < BUF_DEPTH; imem_req_addr = pc_q.
REQ-007 SHALL count accepted requests (valid && ready) as outstanding; each response decrements it; simultaneous accept and response leaves it unchanged.
REQ-008 SHALL, in FETCH, push {rsp_pc_q, imem_rsp_data} into the FIFO on each response; the credit rule of REQ-006 guarantees no overflow.
REQ-009 SHALL drive instr_valid_de0 = FIFO non-empty && !redirect_valid; instr_de0/pc_de0 = FIFO head.
REQ-010 SHALL pop the head when instr_valid_de0 && !stall_de0; push and pop in the same cycle keep occupancy unchanged.
REQ-011 SHALL, on redirect_valid, next cycle: load pc_q and rsp_pc_q with {redirect_pc[31:2],2'b00}, flush the FIFO, set discard count = outstanding minus (imem_rsp_valid ? 1 : 0); go to DRAIN if discard count > 0, else FETCH.
REQ-012 SHALL, in DRAIN, issue no requests, drop every response and decrement discard count; on the response taking it to 0, go to FETCH.
REQ-013 SHALL give a redirect in DRAIN the REQ-011 treatment; the youngest redirect wins.
REQ-014 SHALL drop any response arriving in the redirect cycle (never pushed).
REQ-015 SHALL, without bypass, present an instruction no earlier than the cycle after its response.

Reset
REQ-016 SHALL, while reset is high at a clock edge: pc_q=rsp_pc_q=RESET_PC, FIFO empty, outstanding=0, discard count=0, state IDLE.
REQ-017 SHALL hold imem_req_valid=0 and instr_valid_de0=0 during and the first cycle after reset; in-flight responses arriving after reset SHALL be ignored only if the memory is also reset (system requirement).

Configuration
REQ-018 SHALL honour macro FETCH_BYPASS_EN: when defined, in FETCH with FIFO empty, imem_rsp_valid=1 and redirect_valid=0, instr_de0=imem_rsp_data, pc_de0=rsp_pc_q and instr_valid_de0=1 the same cycle; if stall_de0=0 the entry SHALL NOT be pushed, else pushed normally. When undefined, all responses go through the FIFO per REQ-015.

Verification
REQ-019 Reset release, RESET_PC=0x100, ready=1, 1-cycle memory -> requests 0x100,0x104,... back-to-back; first instr_valid_de0 with pc_de0=0x100 two cycles after first accept (one with FETCH_BYPASS_EN).
REQ-020 stall_de0 held high, ready=1 -> exactly BUF_DEPTH requests issued, then imem_req_valid=0 until a pop; no instruction lost or duplicated.
REQ-021 3 outstanding, redirect to 0x2000 with a response the same cycle -> DRAIN, 2 responses dropped, next request addr 0x2000, first pc_de0=0x2000.
REQ-022 Redirect with 0 outstanding and FIFO non-empty -> instr_valid_de0=0 in redirect cycle, FIFO flushed, FETCH next cycle at new PC.
REQ-023 Redirect to 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-024 Second redirect (0x3000) during DRAIN after first (0x2000) -> fetch resumes at 0x3000; no 0x2000-stream instruction reaches decode.
